// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: ALU-priority write port, LSU result FIFO and load scoreboard.
// Optional macro INT_WB_LSU_BYPASS_EN lets an LSU result skip an empty FIFO.
module int_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  alu_valid_in,
    input  logic [4:0]            alu_rd_addr_in,
    input  logic [DATA_WIDTH-1:0] alu_data_in,
    input  logic                  lsu_valid_in,
    output logic                  lsu_ready_out,
    input  logic [4:0]            lsu_rd_addr_in,
    input  logic [DATA_WIDTH-1:0] lsu_data_in,
    input  logic                  issue_en_in,
    input  logic [4:0]            issue_rd_addr_in,
    input  logic [4:0]            rs_1_addr_in,
    input  logic [4:0]            rs_2_addr_in,
    input  logic [4:0]            dst_addr_in,
    output logic                  stall_out,
    output logic                  wr_en_out,
    output logic [4:0]            rd_addr_out,
    output logic [DATA_WIDTH-1:0] rd_out
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [4:0]            fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [31:0]           pending;
    logic [31:0]           pending_next;
    logic [31:0]           set_mask;
    logic [31:0]           clr_mask;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  accept;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic                  wr_en_next;
    logic [4:0]            rd_addr_next;
    logic [DATA_WIDTH-1:0] rd_next;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty    = (count == '0);
    assign fifo_full     = (count == CNT_W'(FIFO_DEPTH));
    assign lsu_ready_out = (count < CNT_W'(FIFO_DEPTH));
    assign accept        = lsu_valid_in & lsu_ready_out;

`ifdef INT_WB_LSU_BYPASS_EN
    assign bypass = accept & fifo_empty & ~alu_valid_in;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept & ~bypass;
    assign pop  = ~alu_valid_in & ~fifo_empty;

    // Source select for the write port and scoreboard update; ALU always wins.
    always_comb begin
        wr_en_next   = 1'b0;
        rd_addr_next = rd_addr_out;
        rd_next      = rd_out;
        clr_mask     = '0;
        set_mask     = '0;
        if (alu_valid_in) begin
            wr_en_next   = (alu_rd_addr_in != 5'd0);
            rd_addr_next = alu_rd_addr_in;
            rd_next      = alu_data_in;
        end else if (pop) begin
            wr_en_next             = (fifo_rd[rd_ptr] != 5'd0);
            rd_addr_next           = fifo_rd[rd_ptr];
            rd_next                = fifo_data[rd_ptr];
            clr_mask[fifo_rd[rd_ptr]] = 1'b1;
        end else if (bypass) begin
            wr_en_next               = (lsu_rd_addr_in != 5'd0);
            rd_addr_next             = lsu_rd_addr_in;
            rd_next                  = lsu_data_in;
            clr_mask[lsu_rd_addr_in] = 1'b1;
        end
        if (issue_en_in) begin
            set_mask[issue_rd_addr_in] = 1'b1;
        end
        // A set wins over a clear of the same register; x0 never pends.
        pending_next = ((pending & ~clr_mask) | set_mask) & ~32'h1;
    end

    assign stall_out = pending[rs_1_addr_in] | pending[rs_2_addr_in] |
                       pending[dst_addr_in] | fifo_full;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_en_out   <= 1'b0;
            rd_addr_out <= 5'd0;
            rd_out      <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pending     <= '0;
        end else begin
            wr_en_out   <= wr_en_next;
            rd_addr_out <= rd_addr_next;
            rd_out      <= rd_next;
            pending     <= pending_next;
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= lsu_rd_addr_in;
            fifo_data[wr_ptr] <= lsu_data_in;
        end
    end

endmodule

// File: doc/int_wb_arbiter.md
INT_WB_ARBITER -- requirements
Module: int_wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, 2, LSU result buffer entries (legal 2..8).
REQ-002 Parameter: DATA_WIDTH, 32, writeback data width.
REQ-003 Clock and reset: one clock, clk_in; reset is reset_in, asynchronous, active-high.
REQ-004 clk_in  in  1  rising-edge clock.
REQ-005 reset_in  in  1  asynchronous active-high reset.
REQ-006 alu_valid_in  in  1  ALU writeback valid; no backpressure, always accepted.
REQ-007 alu_rd_addr_in  in  5  ALU destination register.
REQ-008 alu_data_in  in  DATA_WIDTH  ALU result.
REQ-009 lsu_valid_in  in  1  load result valid; held stable until accepted.
REQ-010 lsu_ready_out  out  1  load result accepted when valid and ready are both high.
REQ-011 lsu_rd_addr_in  in  5  load destination register.
REQ-012 lsu_data_in  in  DATA_WIDTH  load data.
REQ-013 issue_en_in  in  1  a load to issue_rd_addr_in issues this cycle.
REQ-014 issue_rd_addr_in  in  5  destination of the issuing load.
REQ-015 rs_1_addr_in, rs_2_addr_in, dst_addr_in  in  5 each  operands and destination of the instruction in decode.
REQ-016 stall_out  out  1  decode must hold this cycle.
REQ-017 wr_en_out, rd_addr_out, rd_out  out  1/5/DATA_WIDTH  registered write port to the integer register file.

Function
REQ-018 The write port register SHALL load, each cycle, exactly one source in priority order: ALU (alu_valid_in), FIFO head, else idle (wr_en_out=0).
REQ-019 ALU latency SHALL be 1 cycle: alu_valid_in at cycle N gives wr_en_out=1 at N+1.
REQ-020 wr_en_out SHALL be 0 for any source whose rd is x0; an LSU entry with rd=x0 is still popped.
REQ-021 lsu_ready_out SHALL equal (count < FIFO_DEPTH), from registered count only; no push when full even if popping that cycle.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-023 The FIFO SHALL preserve LSU acceptance order.
REQ-024 Scoreboard: 32 pending bits; issue_en_in sets pending[issue_rd_addr_in] (except x0); an LSU entry loading into the write port register clears pending[rd].
REQ-025 Simultaneous set and clear of the same bit SHALL resolve to set.
REQ-026 stall_out SHALL = pending[rs_1] | pending[rs_2] | pending[dst] | (count == FIFO_DEPTH), combinational from registered state.
REQ-027 pending[0] SHALL read as 0 always.

Reset
REQ-028 On reset_in: wr_en_out=0, rd_addr_out=0, rd_out=0, FIFO count and pointers=0, all pending bits=0; hence lsu_ready_out=1 and stall_out=0.
REQ-029 Reset mid-operation SHALL discard buffered LSU entries and pending state with no write issued.

Configuration
REQ-030 Macro INT_WB_LSU_BYPASS_EN defined: an accepted LSU result with FIFO empty and alu_valid_in=0 SHALL load the write port directly (latency 1) without entering the FIFO.
REQ-031 Macro INT_WB_LSU_BYPASS_EN undefined: every accepted LSU result SHALL enter the FIFO (minimum latency 2).

Verification
REQ-032 Reset, then alu_valid_in=1, rd=5, data=0xDEADBEEF at cycle 1 -> cycle 2 wr_en_out=1, rd_addr_out=5, rd_out=0xDEADBEEF.
REQ-033 ALU and LSU valid together (ALU rd=3 / 0x11; LSU rd=4 / 0x22), then idle -> rd 3 written first; rd 4 next cycle; order and data preserved.
REQ-034 ALU valid every cycle, LSU pushes 2 results -> lsu_ready_out=0 and stall_out=1 once count=2; both written in order once ALU goes idle.
REQ-035 issue_en_in with rd=7; decode rs_1=7 -> stall_out=1 until the LSU result for rd 7 loads the write port, 0 the following cycle; issue and clear of rd 7 in the same cycle -> pending stays 1.
REQ-036 LSU result with rd=0, data 0xFFFFFFFF -> wr_en_out stays 0 and FIFO is popped; reset asserted with 2 entries buffered -> no write, lsu_ready_out=1.
REQ-037 With INT_WB_LSU_BYPASS_EN: LSU rd=9 accepted on an idle cycle -> written next cycle; without the macro -> written two cycles after acceptance.
